// File: rtl/mux_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter_pkg
//   Shared definitions for the round-robin arbiter that drives the select of
//   an external 8x1 multiplexor: requester count, select width, the default
//   hold limit, state encodings, the debug view struct and a one-hot helper.
//   Optional feature macro used by the arbiter: MUX_ARB_TIMEOUT_EN.
// -----------------------------------------------------------------------------
package mux_rr_arbiter_pkg;

  // The requester count is fixed by the mux width and must not be changed.
  localparam int N_REQ    = 8;
  localparam int SEL_W    = 3;
  // Maximum consecutive grant cycles per requester (timeout build only).
  localparam int MAX_HOLD = 4;
  // Width of the saturating hold counter.
  localparam int HOLD_W   = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // Internal state exported for observation. hold_cnt reads zero when the
  // timeout feature is not built in.
  typedef struct packed {
    arb_state_t        state;
    logic [SEL_W-1:0]  ptr;
    logic [HOLD_W-1:0] hold_cnt;
  } arb_dbg_t;

  // One-hot vector with bit 'idx' set. The vector is indexed [0:N_REQ-1] so
  // that requester i always sits at index i.
  function automatic logic [0:N_REQ-1] onehot_sel(input logic [SEL_W-1:0] idx);
    logic [0:N_REQ-1] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin search. Scans req starting at ptr, then
//   ptr+1, ... wrapping modulo N_REQ, and reports the first requester found.
// Ports
//   req  in  [0:N_REQ-1]  request vector
//   ptr  in  [SEL_W-1:0]  search start index
//   any  out 1            at least one request is present
//   win  out [SEL_W-1:0]  index of the first requester at or after ptr
// -----------------------------------------------------------------------------
module rr_pick
  import mux_rr_arbiter_pkg::*;
(
  input  logic [0:N_REQ-1] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] win
);

  logic [SEL_W-1:0] idx;

  // Walk the offsets from farthest to nearest so that the nearest requester
  // (smallest offset from ptr) is the last assignment and therefore wins.
  // The index addition wraps naturally in SEL_W bits.
  always_comb begin
    any = 1'b0;
    win = ptr;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
//   Round-robin arbiter sharing one external 8x1 mux among 8 requesters.
//   Produces the mux select, one-hot grant strobes and a new-grant pulse.
//   All outputs are registered; reset is synchronous and active high.
//
//   Optional feature macro: MUX_ARB_TIMEOUT_EN
//     defined   - a grant is forcibly released after MAX_HOLD cycles
//     undefined - a grant lasts until the grantee drops its request
//
// Ports
//   clk        in   1            clock, all state updates on posedge
//   rst        in   1            synchronous active-high reset
//   req        in   [0:7]        request per requester, held while wanted
//   sel        out  [2:0]        mux select, index of current/last grantee
//   grant      out  [0:7]        one-hot grant, all zero when idle
//   valid      out  1            a grant is active (mux output meaningful)
//   grant_chg  out  1            one-cycle pulse on the first cycle of a grant
//   dbg        out  arb_dbg_t    state, search pointer and hold counter
//
// Handshake: a requester raises req[i] and keeps it high for as long as it
//   wants the mux. It owns the mux in every cycle where grant[i]=1 (valid=1).
//   Dropping req[i] while granted releases the mux at the next clock edge;
//   requests from other requesters never preempt the current grantee.
// -----------------------------------------------------------------------------
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [0:N_REQ-1] req,
  output logic [SEL_W-1:0] sel,
  output logic [0:N_REQ-1] grant,
  output logic             valid,
  output logic             grant_chg,
  output arb_dbg_t         dbg
);

  localparam logic [SEL_W-1:0] SEL_ONE = SEL_W'(1);

  arb_state_t       state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] search_ptr;
  logic             keep;
  logic             any;
  logic [SEL_W-1:0] win;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);
  logic [HOLD_W-1:0] hold_cnt;
`endif

  // keep: the current grantee retains the mux across this edge.
  // search_ptr: on a release the search starts just past the released
  // grantee; in IDLE it starts at the stored pointer.
  always_comb begin
    keep = req[sel];
`ifdef MUX_ARB_TIMEOUT_EN
    if (hold_cnt == HOLD_LIMIT) keep = 1'b0;
`endif
    search_ptr = (state == ST_GRANT) ? (sel + SEL_ONE) : ptr;
  end

  rr_pick u_rr_pick (
    .req (req),
    .ptr (search_ptr),
    .any (any),
    .win (win)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      sel       <= '0;
      grant     <= '0;
      valid     <= 1'b0;
      grant_chg <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      hold_cnt  <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          grant_chg <= 1'b0;
          if (any) begin
            state     <= ST_GRANT;
            sel       <= win;
            grant     <= onehot_sel(win);
            valid     <= 1'b1;
            grant_chg <= 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
          end
        end
        ST_GRANT: begin
          if (keep) begin
            grant_chg <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
            if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
`endif
          end else begin
            // Release: advance the pointer and hand over in the same edge
            // when someone else (or the same requester) is waiting.
            ptr <= search_ptr;
            if (any) begin
              sel       <= win;
              grant     <= onehot_sel(win);
              valid     <= 1'b1;
              grant_chg <= 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
              hold_cnt  <= '0;
`endif
            end else begin
              state     <= ST_IDLE;
              grant     <= '0;
              valid     <= 1'b0;
              grant_chg <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    dbg.state    = state;
    dbg.ptr      = ptr;
`ifdef MUX_ARB_TIMEOUT_EN
    dbg.hold_cnt = hold_cnt;
`else
    dbg.hold_cnt = '0;
`endif
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_arbiter
//   Directed-vector bench for mux_rr_arbiter. Inputs change 1 ns after a
//   rising edge; outputs are sampled at that same point, i.e. they show the
//   result of the edge just passed.
// -----------------------------------------------------------------------------
module tb_mux_rr_arbiter;
  import mux_rr_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [0:7] req = '0;
  logic [2:0] sel;
  logic [0:7] grant;
  logic       valid;
  logic       grant_chg;
  arb_dbg_t   dbg;

  mux_rr_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .sel       (sel),
    .grant     (grant),
    .valid     (valid),
    .grant_chg (grant_chg),
    .dbg       (dbg)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Packed observation: {sel, grant[0..7], valid, grant_chg}
  logic [12:0] obs;
  assign obs = {sel, grant, valid, grant_chg};

  // ---------------- expected-value helpers ----------------
  function automatic logic [0:7] gv(input int i);
    logic [0:7] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [12:0] mk(input int s, input logic [0:7] g,
                                     input logic v, input logic c);
    return {3'(s), g, v, c};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    logic [12:0] exp;
    rst = 1'b1;
    req = '1;
    tick();
    tick();
    exp = mk(0, '0, 1'b0, 1'b0);
    total_cnt++;
    if (obs !== exp) $display("FAIL reset_outputs obs=%h exp=%h", obs, exp);
    else pass_cnt++;
    total_cnt++;
    if (dbg.ptr !== 3'd0) $display("FAIL reset_ptr got=%0d exp=0", dbg.ptr);
    else pass_cnt++;
    total_cnt++;
    if (dbg.state !== ST_IDLE) $display("FAIL reset_state got=%0d exp=%0d", dbg.state, ST_IDLE);
    else pass_cnt++;
    req = '0;
    rst = 1'b0;
    tick();
    exp = mk(0, '0, 1'b0, 1'b0);
    total_cnt++;
    if (obs !== exp) $display("FAIL idle_after_reset obs=%h exp=%h", obs, exp);
    else pass_cnt++;
  endtask

  task automatic test_single_grant;
    logic [12:0] exp;
    req = gv(2);
    tick();
    exp = mk(2, gv(2), 1'b1, 1'b1);
    total_cnt++;
    if (obs !== exp) $display("FAIL single_first obs=%h exp=%h", obs, exp);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp = mk(2, gv(2), 1'b1, 1'b0);
      total_cnt++;
      if (obs !== exp) $display("FAIL single_hold%0d obs=%h exp=%h", k, obs, exp);
      else pass_cnt++;
    end
    req = '0;
    tick();
    exp = mk(2, '0, 1'b0, 1'b0);
    total_cnt++;
    if (obs !== exp) $display("FAIL single_release obs=%h exp=%h", obs, exp);
    else pass_cnt++;
    total_cnt++;
    if (dbg.ptr !== 3'd3) $display("FAIL single_ptr got=%0d exp=3", dbg.ptr);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (obs !== exp) $display("FAIL single_idle_stable obs=%h exp=%h", obs, exp);
    else pass_cnt++;
  endtask

  // ptr=3 on entry. Grant 4, add a competitor, no preemption, then a
  // handover with no idle bubble; search from 5 wraps around to 3.
  task automatic test_no_preempt;
    logic [12:0] exp;
    req = gv(4);
    tick();
    exp = mk(4, gv(4), 1'b1, 1'b1);
    total_cnt++;
    if (obs !== exp) $display("FAIL np_grant4 obs=%h exp=%h", obs, exp);
    else pass_cnt++;
    req = gv(4) | gv(3);
    tick();
    exp = mk(4, gv(4), 1'b1, 1'b0);
    total_cnt++;
    if (obs !== exp) $display("FAIL np_keep4 obs=%h exp=%h", obs, exp);
    else pass_cnt++;
    req = gv(3);
    tick();
    exp = mk(3, gv(3), 1'b1, 1'b1);
    total_cnt++;
    if (obs !== exp) $display("FAIL np_handover3 obs=%h exp=%h", obs, exp);
    else pass_cnt++;
    total_cnt++;
    if (dbg.ptr !== 3'd5) $display("FAIL np_ptr got=%0d exp=5", dbg.ptr);
    else pass_cnt++;
    req = '0;
    tick();
    exp = mk(3, '0, 1'b0, 1'b0);
    total_cnt++;
    if (obs !== exp) $display("FAIL np_idle obs=%h exp=%h", obs, exp);
    else pass_cnt++;
  endtask

  // All requesting; each grantee drops for one cycle, one cycle after its
  // grant pulse, then re-raises. Expected order 0..7,0 with no gaps.
  task automatic test_rotation;
    logic [12:0] exp;
    int w;
    do_reset();
    req = '1;
    tick();
    for (int k = 0; k < 9; k++) begin
      w = k % 8;
      exp = mk(w, gv(w), 1'b1, 1'b1);
      total_cnt++;
      if (obs !== exp) $display("FAIL rot_grant%0d obs=%h exp=%h", k, obs, exp);
      else pass_cnt++;
      tick();
      exp = mk(w, gv(w), 1'b1, 1'b0);
      total_cnt++;
      if (obs !== exp) $display("FAIL rot_hold%0d obs=%h exp=%h", k, obs, exp);
      else pass_cnt++;
      req[w] = 1'b0;
      tick();
      req[w] = 1'b1;
    end
    // Grant 1 is active now; drop everything and expect a clean idle.
    exp = mk(1, gv(1), 1'b1, 1'b1);
    total_cnt++;
    if (obs !== exp) $display("FAIL rot_last obs=%h exp=%h", obs, exp);
    else pass_cnt++;
    req = '0;
    tick();
    exp = mk(1, '0, 1'b0, 1'b0);
    total_cnt++;
    if (obs !== exp) $display("FAIL rot_idle obs=%h exp=%h", obs, exp);
    else pass_cnt++;
  endtask

`ifdef MUX_ARB_TIMEOUT_EN
  // req[5] first, then req[1] joins: 5 for 4 cycles, 1 for 4, then 5 again.
  task automatic test_timeout;
    logic [12:0] exp;
    int seq [3] = '{5, 1, 5};
    do_reset();
    req = gv(5);
    tick();
    req = gv(5) | gv(1);
    for (int g = 0; g < 3; g++) begin
      for (int c = 0; c < 4; c++) begin
        exp = mk(seq[g], gv(seq[g]), 1'b1, (c == 0) ? 1'b1 : 1'b0);
        total_cnt++;
        if (obs !== exp) $display("FAIL to_g%0d_c%0d obs=%h exp=%h", g, c, obs, exp);
        else pass_cnt++;
        tick();
      end
    end
    req = '0;
    tick();
    tick();
    exp = mk(1, '0, 1'b0, 1'b0);
    total_cnt++;
    if (obs !== exp) $display("FAIL to_idle obs=%h exp=%h", obs, exp);
    else pass_cnt++;
  endtask
`else
  // Same stimulus without the timeout: grant[5] held all 20 cycles.
  task automatic test_unbounded_hold;
    logic [12:0] exp;
    int held;
    int pulses;
    held   = 0;
    pulses = 0;
    do_reset();
    req = gv(5);
    tick();
    req = gv(5) | gv(1);
    for (int c = 0; c < 20; c++) begin
      if (grant === gv(5) && sel === 3'd5 && valid === 1'b1) held++;
      if (grant_chg === 1'b1) pulses++;
      tick();
    end
    total_cnt++;
    if (held != 20) $display("FAIL ub_held got=%0d exp=20", held);
    else pass_cnt++;
    total_cnt++;
    if (pulses != 1) $display("FAIL ub_pulses got=%0d exp=1", pulses);
    else pass_cnt++;
    // Releasing 5 hands over directly to 1 (search from 6 wraps to 1).
    req = gv(1);
    tick();
    exp = mk(1, gv(1), 1'b1, 1'b1);
    total_cnt++;
    if (obs !== exp) $display("FAIL ub_handover obs=%h exp=%h", obs, exp);
    else pass_cnt++;
    req = '0;
    tick();
  endtask
`endif

  task automatic test_reset_mid_grant;
    logic [12:0] exp;
    req = gv(6);
    tick();
    exp = mk(6, gv(6), 1'b1, 1'b1);
    total_cnt++;
    if (obs !== exp) $display("FAIL rm_grant6 obs=%h exp=%h", obs, exp);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    exp = mk(0, '0, 1'b0, 1'b0);
    total_cnt++;
    if (obs !== exp) $display("FAIL rm_abort obs=%h exp=%h", obs, exp);
    else pass_cnt++;
    total_cnt++;
    if (dbg.state !== ST_IDLE || dbg.ptr !== 3'd0)
      $display("FAIL rm_dbg state=%0d ptr=%0d exp state=0 ptr=0", dbg.state, dbg.ptr);
    else pass_cnt++;
    rst = 1'b0;
    tick();
    exp = mk(6, gv(6), 1'b1, 1'b1);
    total_cnt++;
    if (obs !== exp) $display("FAIL rm_regrant obs=%h exp=%h", obs, exp);
    else pass_cnt++;
    req = '0;
    tick();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_grant();
    test_no_preempt();
    test_rotation();
`ifdef MUX_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_unbounded_hold();
`endif
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
